// File: rtl/calc_n.sv
// N-port two-operand calculator: per-port capture FSM and request FIFO feeding one shared,
// round-robin arbitrated ALU. Define CALC_SHIFT_EN to build the shifter for cmd 5/6.
module calc_n #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CMD_WIDTH  = 4,
    parameter int RESP_WIDTH = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS*CMD_WIDTH-1:0]   req_cmd_in,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_data_in,
    output logic [NUM_PORTS-1:0]             req_ready,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  out_data,
    output logic [NUM_PORTS*RESP_WIDTH-1:0]  out_resp
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int PORT_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int ENTRY_W = CMD_WIDTH + 2 * DATA_WIDTH;
    localparam logic [RESP_WIDTH-1:0] RESP_OK  = RESP_WIDTH'(1);
    localparam logic [RESP_WIDTH-1:0] RESP_ERR = RESP_WIDTH'(2);

    typedef enum logic {S_IDLE = 1'b0, S_OP2 = 1'b1} state_t;

    logic                  run_reg;
    logic [NUM_PORTS-1:0]  nonempty;
    logic [NUM_PORTS-1:0]  grant;
    logic [ENTRY_W-1:0]    head_entry [NUM_PORTS];
    logic                  grant_valid;
    logic [PORT_W-1:0]     grant_idx;
    logic [PORT_W-1:0]     arb_ptr_reg, arb_ptr_next;
    logic                  res_valid_reg;
    logic [PORT_W-1:0]     res_port_reg;
    logic [DATA_WIDTH-1:0] res_data_reg, alu_data;
    logic [RESP_WIDTH-1:0] res_resp_reg, alu_resp;

    // Held low through reset so req_ready only rises on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) run_reg <= 1'b0;
        else     run_reg <= 1'b1;
    end

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            state_t                state_reg, state_next;
            logic [CMD_WIDTH-1:0]  cmd_in, cmd_reg;
            logic [DATA_WIDTH-1:0] data_in, op1_reg;
            logic [ENTRY_W-1:0]    mem [FIFO_DEPTH];
            logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
            logic [CNT_W-1:0]      count_reg;
            logic                  ready, accept, push, pop;

            assign cmd_in  = req_cmd_in[gi*CMD_WIDTH +: CMD_WIDTH];
            assign data_in = req_data_in[gi*DATA_WIDTH +: DATA_WIDTH];
            assign pop     = grant[gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) state_reg <= S_IDLE;
                else     state_reg <= state_next;
            end

            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    S_IDLE:  if (accept) state_next = S_OP2;
                    default: state_next = S_IDLE;
                endcase
            end

            // Occupancy only falls while in OP2, so the push that ends OP2 always has room.
            always_comb begin
                ready  = run_reg && (state_reg == S_IDLE) && (count_reg < CNT_W'(FIFO_DEPTH));
                accept = ready && (cmd_in != '0);
                push   = (state_reg == S_OP2);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cmd_reg <= '0;
                    op1_reg <= '0;
                end else if (accept) begin
                    cmd_reg <= cmd_in;
                    op1_reg <= data_in;
                end
            end

            always_ff @(posedge clk) begin
                if (push) mem[wr_ptr_reg] <= {cmd_reg, op1_reg, data_in};
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
                    else if (pop && !push) count_reg <= count_reg - CNT_W'(1);
                end
            end

            assign req_ready[gi]  = ready;
            assign nonempty[gi]   = (count_reg != '0);
            assign head_entry[gi] = mem[rd_ptr_reg];
            assign out_resp[gi*RESP_WIDTH +: RESP_WIDTH] =
                (res_valid_reg && res_port_reg == PORT_W'(gi)) ? res_resp_reg : '0;
            assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] =
                (res_valid_reg && res_port_reg == PORT_W'(gi)) ? res_data_reg : '0;
        end
    endgenerate

    // Round-robin: scan from arb_ptr_reg, which always points one past the last grant.
    always_comb begin
        int k;
        k            = 0;
        grant_valid  = 1'b0;
        grant_idx    = '0;
        grant        = '0;
        arb_ptr_next = arb_ptr_reg;
        for (int i = 0; i < NUM_PORTS; i++) begin
            k = int'(arb_ptr_reg) + i;
            if (k >= NUM_PORTS) k = k - NUM_PORTS;
            if (!grant_valid && nonempty[k]) begin
                grant_valid = 1'b1;
                grant_idx   = PORT_W'(k);
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
            arb_ptr_next = (int'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + PORT_W'(1);
        end
    end

    logic [CMD_WIDTH-1:0]  alu_cmd;
    logic [DATA_WIDTH-1:0] alu_a, alu_b;
    logic [DATA_WIDTH:0]   alu_sum;

    assign {alu_cmd, alu_a, alu_b} = head_entry[grant_idx];
    assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b};

`ifdef CALC_SHIFT_EN
    localparam int SH_W = $clog2(DATA_WIDTH);
`endif

    // Overflow, underflow and unknown commands all collapse to an error with zero data.
    always_comb begin
        alu_resp = RESP_ERR;
        alu_data = '0;
        case (alu_cmd)
            CMD_WIDTH'(1): if (!alu_sum[DATA_WIDTH]) begin
                alu_resp = RESP_OK;
                alu_data = alu_sum[DATA_WIDTH-1:0];
            end
            CMD_WIDTH'(2): if (alu_b <= alu_a) begin
                alu_resp = RESP_OK;
                alu_data = alu_a - alu_b;
            end
`ifdef CALC_SHIFT_EN
            CMD_WIDTH'(5): begin
                alu_resp = RESP_OK;
                alu_data = alu_a << alu_b[SH_W-1:0];
            end
            CMD_WIDTH'(6): begin
                alu_resp = RESP_OK;
                alu_data = alu_a >> alu_b[SH_W-1:0];
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_reg <= 1'b0;
            res_port_reg  <= '0;
            res_data_reg  <= '0;
            res_resp_reg  <= '0;
            arb_ptr_reg   <= '0;
        end else begin
            res_valid_reg <= grant_valid;
            res_port_reg  <= grant_idx;
            res_data_reg  <= alu_data;
            res_resp_reg  <= alu_resp;
            arb_ptr_reg   <= arb_ptr_next;
        end
    end
endmodule

// File: tb/tb_calc_n.sv
// Scoreboard bench for calc_n: expected results are queued per port at stimulus time and
// popped by a negedge monitor; directed sections also pin exact latency and grant order.
module tb_calc_n;
    localparam int NP = 4;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int RW = 2;
    localparam int FD = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP*CW-1:0]  req_cmd_in  = '0;
    logic [NP*DW-1:0]  req_data_in = '0;
    logic [NP-1:0]     req_ready;
    logic [NP*DW-1:0]  out_data;
    logic [NP*RW-1:0]  out_resp;

    calc_n #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .CMD_WIDTH(CW), .RESP_WIDTH(RW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
        .req_ready(req_ready), .out_data(out_data), .out_resp(out_resp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RW-1:0] resp;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q [NP][$];
    int   asserts_cnt = 0;
    int   fail_cnt    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        asserts_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [CW-1:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t        e;
        logic [DW:0] s;
        e.resp = 2'd2;
        e.data = '0;
        s = {1'b0, a} + {1'b0, b};
        case (c)
            4'd1: if (!s[DW]) begin e.resp = 2'd1; e.data = s[DW-1:0]; end
            4'd2: if (b <= a) begin e.resp = 2'd1; e.data = a - b; end
`ifdef CALC_SHIFT_EN
            4'd5: begin e.resp = 2'd1; e.data = a << b[4:0]; end
            4'd6: begin e.resp = 2'd1; e.data = a >> b[4:0]; end
`endif
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [DW-1:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return DW'($urandom);
            1:       return 32'hFFFF_FFF0 + DW'($urandom_range(0, 15));
            default: return DW'($urandom_range(0, 40));
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic [CW-1:0] c, input logic [DW-1:0] d);
        req_cmd_in[p*CW +: CW]  = c;
        req_data_in[p*DW +: DW] = d;
    endtask

    task automatic clear_inputs();
        req_cmd_in  = '0;
        req_data_in = '0;
    endtask

    function automatic logic [NP*RW-1:0] resp_vec(input int p, input logic [RW-1:0] r);
        logic [NP*RW-1:0] v;
        v = '0;
        v[p*RW +: RW] = r;
        return v;
    endfunction

    // Response monitor: every nonzero response must match the head of that port's queue.
    always @(negedge clk) begin
        int            active;
        logic [RW-1:0] r;
        logic [DW-1:0] d;
        exp_t          e;
        if (!rst) begin
            active = 0;
            for (int p = 0; p < NP; p++) begin
                r = out_resp[p*RW +: RW];
                d = out_data[p*DW +: DW];
                if (r != '0) begin
                    active++;
                    if (exp_q[p].size() == 0) begin
                        check($sformatf("unexpected_resp_p%0d", p), 64'(r), 64'd0);
                    end else begin
                        e = exp_q[p].pop_front();
                        check($sformatf("resp_p%0d", p), 64'(r), 64'(e.resp));
                        check($sformatf("data_p%0d", p), 64'(d), 64'(e.data));
                        $display("port %0d: resp=%0d data=%08h (exp %0d/%08h)", p, r, d, e.resp, e.data);
                    end
                end else begin
                    check($sformatf("idle_data_p%0d", p), 64'(d), 64'd0);
                end
            end
            check("single_resp", 64'(active <= 1), 64'd1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int               ph [NP];
    logic [CW-1:0]    pc [NP];
    logic [DW-1:0]    pa [NP];
    int               drops [NP];
    logic [CW-1:0]    cmd_tab [8];
    logic [CW-1:0]    c;
    logic [DW-1:0]    a, b;
    bit               all_empty;

    initial begin
        cmd_tab = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd5, 4'd6, 4'd3, 4'd15};
        for (int p = 0; p < NP; p++) begin ph[p] = 0; drops[p] = 0; end

        // Reset state and release timing
        #3;
        check("rst_resp", 64'(out_resp), 64'd0);
        check("rst_data_nonzero", 64'(out_data != '0), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_before_edge", 64'(req_ready), 64'd0);
        tick();
        check("ready_after_edge", 64'(req_ready), 64'hF);

        // All ports add 1+1 together: grants come out 0,1,2,3 on consecutive cycles
        for (int p = 0; p < NP; p++) drive(p, 4'd1, 32'd1);
        tick();
        check("ready_all_op2", 64'(req_ready), 64'd0);
        for (int p = 0; p < NP; p++) begin
            drive(p, 4'd0, 32'd1);
            exp_q[p].push_back(model(4'd1, 32'd1, 32'd1));
        end
        tick();
        clear_inputs();
        tick();
        for (int p = 0; p < NP; p++) begin
            check($sformatf("rr_order_%0d", p), 64'(out_resp), 64'(resp_vec(p, 2'd1)));
            check($sformatf("rr_data_%0d", p), 64'(out_data[p*DW +: DW]), 64'd2);
            tick();
        end

        // 5 + 7 on port 0, exactly three cycles after the command
        drive(0, 4'd1, 32'd5);
        tick();
        drive(0, 4'd0, 32'd7);
        exp_q[0].push_back(model(4'd1, 32'd5, 32'd7));
        tick();
        clear_inputs();
        check("add_not_early", 64'(out_resp), 64'd0);
        tick();
        check("add_resp", 64'(out_resp), 64'(resp_vec(0, 2'd1)));
        check("add_data", 64'(out_data[0 +: DW]), 64'h0000_000C);

        // Carry on port 2, underflow on port 1
        drive(2, 4'd1, 32'hFFFF_FFFF);
        drive(1, 4'd2, 32'd3);
        tick();
        drive(2, 4'd0, 32'd1);
        drive(1, 4'd0, 32'd4);
        exp_q[2].push_back(model(4'd1, 32'hFFFF_FFFF, 32'd1));
        exp_q[1].push_back(model(4'd2, 32'd3, 32'd4));
        tick();
        clear_inputs();
        tick();
        check("sub_uflow_resp", 64'(out_resp), 64'(resp_vec(1, 2'd2)));
        check("sub_uflow_data_nonzero", 64'(out_data != '0), 64'd0);
        tick();
        check("add_carry_resp", 64'(out_resp), 64'(resp_vec(2, 2'd2)));
        check("add_carry_data_nonzero", 64'(out_data != '0), 64'd0);

        // Shift left 1 by 0x24 (amount 4)
        drive(0, 4'd5, 32'd1);
        tick();
        drive(0, 4'd0, 32'h24);
        exp_q[0].push_back(model(4'd5, 32'd1, 32'h24));
        tick();
        clear_inputs();
        tick();
`ifdef CALC_SHIFT_EN
        check("shl_resp", 64'(out_resp), 64'(resp_vec(0, 2'd1)));
        check("shl_data", 64'(out_data[0 +: DW]), 64'h10);
`else
        check("shl_resp", 64'(out_resp), 64'(resp_vec(0, 2'd2)));
        check("shl_data", 64'(out_data[0 +: DW]), 64'h0);
`endif

        // Contention: every port attempts back-to-back commands so the FIFOs fill
        for (int cyc = 0; cyc < 80; cyc++) begin
            for (int p = 0; p < NP; p++) begin
                if (ph[p] == 1) begin
                    check($sformatf("ready_op2_p%0d", p), 64'(req_ready[p]), 64'd0);
                    b = rand_op();
                    drive(p, CW'($urandom_range(1, 15)), b);
                    exp_q[p].push_back(model(pc[p], pa[p], b));
                    ph[p] = 0;
                end else begin
                    c = cmd_tab[$urandom_range(0, 7)];
                    a = rand_op();
                    drive(p, c, a);
                    if (req_ready[p]) begin
                        ph[p] = 1;
                        pc[p] = c;
                        pa[p] = a;
                    end else begin
                        drops[p]++;
                    end
                end
            end
            tick();
        end
        clear_inputs();
        for (int p = 0; p < NP; p++) begin
            if (ph[p] == 1) begin
                b = rand_op();
                drive(p, 4'd0, b);
                exp_q[p].push_back(model(pc[p], pa[p], b));
                ph[p] = 0;
            end
        end
        tick();
        clear_inputs();
        check("p3_full_drop_seen", 64'(drops[3] > 0), 64'd1);

        for (int i = 0; i < 400; i++) begin
            all_empty = 1'b1;
            for (int p = 0; p < NP; p++) if (exp_q[p].size() != 0) all_empty = 1'b0;
            if (all_empty) break;
            tick();
        end
        for (int p = 0; p < NP; p++) check($sformatf("drain_p%0d", p), 64'(exp_q[p].size()), 64'd0);
        repeat (3) tick();

        // Reset in the middle of a burst with three requests still queued
        for (int p = 0; p < NP; p++) drive(p, 4'd1, DW'(p + 1));
        tick();
        for (int p = 0; p < NP; p++) begin
            drive(p, 4'd0, 32'd1);
            exp_q[p].push_back(model(4'd1, DW'(p + 1), 32'd1));
        end
        tick();
        clear_inputs();
        tick();
        check("burst_resp_live", 64'(out_resp != '0), 64'd1);
        #1;
        for (int p = 0; p < NP; p++) exp_q[p].delete();
        rst = 1'b1;
        #1;
        check("async_rst_resp", 64'(out_resp), 64'd0);
        check("async_rst_data_nonzero", 64'(out_data != '0), 64'd0);
        check("async_rst_ready", 64'(req_ready), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rel_ready_before_edge", 64'(req_ready), 64'd0);
        tick();
        check("rel_ready_after_edge", 64'(req_ready), 64'hF);
        repeat (12) tick();

        // Clean operation after reset: 10 - 3 on port 1 with the arbiter back at port 0
        drive(1, 4'd2, 32'd10);
        tick();
        drive(1, 4'd0, 32'd3);
        exp_q[1].push_back(model(4'd2, 32'd10, 32'd3));
        tick();
        clear_inputs();
        tick();
        check("post_rst_resp", 64'(out_resp), 64'(resp_vec(1, 2'd1)));
        check("post_rst_data", 64'(out_data[DW +: DW]), 64'd7);
        repeat (3) tick();
        for (int p = 0; p < NP; p++) check($sformatf("final_empty_p%0d", p), 64'(exp_q[p].size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts_cnt, fail_cnt);
        $finish;
    end
endmodule
